obf_key_loader: RTL



---
 rtl/obf_key_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/obf_key_loader.sv
// -----------------------------------------------------------------------------
// obf_key_loader
// Serial key-load controller for a MUX2-locked combinational core. The key is
// shifted in LSB first into a shadow register, followed by one even-parity
// bit. Once parity checks out, the whole shadow is copied onto s_key on a
// single edge, so the locked core never sees a partially loaded key.
//
// Optional feature, enabled by defining OBF_KEY_LOCK_EN:
//   After the first successful load the key becomes write-once until rst.
//   Further requests are refused in IDLE. Each rising edge of key_load_req
//   pulses key_err for one cycle.
// -----------------------------------------------------------------------------
module obf_key_loader #(
    parameter int KEY_W = 12,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load_req,
    input  logic             key_sen,
    input  logic             key_sdi,
    output logic             key_load_ack,
    output logic             busy,
    output logic             key_valid,
    output logic             key_err,
    output logic [KEY_W-1:0] s_key
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_APPLY = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    // Returns 1 when the key plus its parity bit does not have even parity.
    function automatic logic parity_fail(input logic [KEY_W-1:0] vec, input logic pbit);
        return (^vec) ^ pbit;
    endfunction

    logic [2:0]       state_r,     state_nxt;
    logic [CNT_W-1:0] cnt_r,       cnt_nxt;
    logic [KEY_W-1:0] shadow_r,    shadow_nxt;
    logic             pbit_r,      pbit_nxt;
    logic [KEY_W-1:0] s_key_r,     s_key_nxt;
    logic             key_valid_r, key_valid_nxt;
    logic             key_err_r,   key_err_nxt;
    logic             ack_r,       ack_nxt;
    logic             busy_r,      busy_nxt;
    logic             start_ok_s;

`ifdef OBF_KEY_LOCK_EN
    logic             lock_r,      lock_nxt;
    logic             req_d_r;

    // A new transfer may only start while the key has not been locked yet.
    assign start_ok_s = key_load_req & ~lock_r;
`else
    // Reloading is always permitted.
    assign start_ok_s = key_load_req;
`endif

    // Next-state and next-output computation for the load sequence.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        shadow_nxt    = shadow_r;
        pbit_nxt      = pbit_r;
        s_key_nxt     = s_key_r;
        key_valid_nxt = key_valid_r;
        key_err_nxt   = key_err_r;
        ack_nxt       = ack_r;
`ifdef OBF_KEY_LOCK_EN
        lock_nxt      = lock_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt     = ST_SHIFT;
                    cnt_nxt       = {CNT_W{1'b0}};
                    shadow_nxt    = {KEY_W{1'b0}};
                    key_err_nxt   = 1'b0;
                    key_valid_nxt = 1'b0;
                end else begin
`ifdef OBF_KEY_LOCK_EN
                    // While locked, flag each new request for one cycle.
                    key_err_nxt = lock_r ? (key_load_req & ~req_d_r) : key_err_r;
`else
                    key_err_nxt = key_err_r;
`endif
                end
            end
            ST_SHIFT: begin
                // A dropped request aborts the transfer before any data is taken.
                if (!key_load_req) begin
                    state_nxt   = ST_IDLE;
                    key_err_nxt = 1'b1;
                end else if (key_sen) begin
                    if (cnt_r == CNT_W'(KEY_W)) begin
                        pbit_nxt  = key_sdi;
                        state_nxt = ST_CHECK;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                shadow_nxt[i] = key_sdi;
                            end else begin
                                shadow_nxt[i] = shadow_r[i];
                            end
                        end
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (parity_fail(shadow_r, pbit_r)) begin
                    state_nxt   = ST_IDLE;
                    key_err_nxt = 1'b1;
                end else begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                // Whole key goes out on one edge; the core never sees a mix.
                s_key_nxt     = shadow_r;
                key_valid_nxt = 1'b1;
                ack_nxt       = 1'b1;
                state_nxt     = ST_ACK;
`ifdef OBF_KEY_LOCK_EN
                lock_nxt      = 1'b1;
`endif
            end
            ST_ACK: begin
                if (!key_load_req) begin
                    ack_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    ack_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shadow_r    <= {KEY_W{1'b0}};
            pbit_r      <= 1'b0;
            s_key_r     <= {KEY_W{1'b0}};
            key_valid_r <= 1'b0;
            key_err_r   <= 1'b0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            shadow_r    <= shadow_nxt;
            pbit_r      <= pbit_nxt;
            s_key_r     <= s_key_nxt;
            key_valid_r <= key_valid_nxt;
            key_err_r   <= key_err_nxt;
            ack_r       <= ack_nxt;
            busy_r      <= busy_nxt;
        end
    end

`ifdef OBF_KEY_LOCK_EN
    // Lock bit and request history used for the locked-request error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r  <= 1'b0;
            req_d_r <= 1'b0;
        end else begin
            lock_r  <= lock_nxt;
            req_d_r <= key_load_req;
        end
    end
`endif

    assign key_load_ack = ack_r;
    assign busy         = busy_r;
    assign key_valid    = key_valid_r;
    assign key_err      = key_err_r;
    assign s_key        = s_key_r;

endmodule
